// File: rtl/qspi_sram_pkg.sv
// qspi_sram_pkg: shared definitions for the serial SRAM responder.
//   Opcodes, FSM state encoding, protocol byte counts and the serial
//   shift-in helper used by qspi_sram_responder.
package qspi_sram_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_EQIO  = 8'h38;
    localparam logic [7:0] CMD_RSTIO = 8'hFF;

    localparam int ADDR_BYTES      = 3;
    localparam int SQI_DUMMY_BYTES = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    // MSB-first shift: one bit on sio0 (SPI) or a nibble on sio[3:0] (SQI).
    function automatic logic [7:0] shift_in(input logic [7:0] sh,
                                            input logic [3:0] sio,
                                            input logic       quad);
        return quad ? {sh[3:0], sio} : {sh[6:0], sio[0]};
    endfunction

endpackage

// File: rtl/qspi_sram_responder_edge_sync.sv
// qspi_edge_sync: brings cs_n/sck/sio into the clk domain and produces
// single-clk pulses on sck rise/fall and cs_n rise/fall.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cs_n, sck, sio[3:0] raw serial pins
//   cs_n_sync, sio_sync synchronized copies
//   sck_rise, sck_fall  1-clk pulses on synchronized sck edges
//   cs_rise, cs_fall    1-clk pulses on synchronized cs_n edges
// SYNC_STAGES = 0 passes the pins straight through (already in clk domain).
module qspi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       sck,
    input  logic [3:0] sio,
    output logic       cs_n_sync,
    output logic [3:0] sio_sync,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       cs_rise,
    output logic       cs_fall
);

    // Idle bus value: deselected, sck low. Reset to this so leaving reset
    // never fabricates an edge.
    localparam logic [5:0] IDLE_BUS = 6'b10_0000;

    logic [5:0] raw_bus;
    logic [5:0] sync_bus;
    logic       cs_prev;
    logic       sck_prev;

    assign raw_bus = {cs_n, sck, sio};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_bus = raw_bus;
        end else begin : g_sync
            logic [5:0] chain [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= IDLE_BUS;
                end else begin
                    chain[0] <= raw_bus;
                    for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
                end
            end
            assign sync_bus = chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
        end else begin
            cs_prev  <= sync_bus[5];
            sck_prev <= sync_bus[4];
        end
    end

    assign cs_n_sync = sync_bus[5];
    assign sio_sync  = sync_bus[3:0];
    assign sck_rise  =  sync_bus[4] & ~sck_prev;
    assign sck_fall  = ~sync_bus[4] &  sck_prev;
    assign cs_rise   =  sync_bus[5] & ~cs_prev;
    assign cs_fall   = ~sync_bus[5] &  cs_prev;

endmodule

// File: rtl/qspi_sram_responder.sv
// qspi_sram_responder: responder model of a 23LC1024-style serial SRAM.
// Decodes WRITE/READ/EQIO/RSTIO in SPI or SQI mode, holds a byte array
// and returns read data MSB first (sample on sck rise, drive on sck fall).
// Ports:
//   clk, reset              oversampling clock (>= 4x sck), sync active-high reset
//   sram_cs_n, sram_sck     chip select (active low), serial clock (mode 0)
//   sram_sio_i[3:0]         data from initiator (sio0 = SI in SPI mode)
//   sram_sio_o[3:0]         data to initiator (sio1 = SO in SPI mode)
//   sram_sio_oe[3:0]        per-line output enable
//   quad_mode               SQI mode active (set by EQIO, cleared by RSTIO/reset)
//   active                  synchronized cs_n low
//   cmd_error               sticky unsupported-opcode flag
// Optional macro QSPI_SRAM_RESP_BACKDOOR_EN adds bd_we/bd_addr/bd_wdata/bd_rdata
// for direct array preload and inspection (backdoor write wins on collision).
module qspi_sram_responder
    import qspi_sram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 17,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sram_cs_n,
    input  logic                      sram_sck,
    input  logic [3:0]                sram_sio_i,
    output logic [3:0]                sram_sio_o,
    output logic [3:0]                sram_sio_oe,
    output logic                      quad_mode,
    output logic                      active,
    output logic                      cmd_error
`ifdef QSPI_SRAM_RESP_BACKDOOR_EN
    ,
    input  logic                      bd_we,
    input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
    input  logic [7:0]                bd_wdata,
    output logic [7:0]                bd_rdata
`endif
);

    logic       cs_n_sync, sck_rise, sck_fall, cs_rise, cs_fall;
    logic [3:0] sio_sync;

    qspi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (sram_cs_n),
        .sck       (sram_sck),
        .sio       (sram_sio_i),
        .cs_n_sync (cs_n_sync),
        .sio_sync  (sio_sync),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall)
    );

    state_t                    state, state_nx;
    logic [7:0]                rx_sh, rx_byte;
    logic [2:0]                bit_cnt, bit_last, tx_cnt;
    logic [1:0]                byte_cnt;
    logic                      is_read;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [7:0]                dout, mem_q;
    logic                      rise, fall, byte_done, mem_we;

    // A cs_n rise in the same clk as an sck edge wins: the edge is dropped.
    assign rise      = sck_rise & ~cs_rise & (state != ST_IDLE);
    assign fall      = sck_fall & ~cs_rise & (state != ST_IDLE);
    assign bit_last  = quad_mode ? 3'd1 : 3'd7;
    assign rx_byte   = shift_in(rx_sh, sio_sync, quad_mode);
    assign byte_done = rise & (bit_cnt == bit_last);

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        if (cs_rise) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (cs_fall) state_nx = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) state_nx = ST_ADDR;
                        else                                             state_nx = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (byte_done && byte_cnt == 2'(ADDR_BYTES-1)) begin
                        if (!is_read)      state_nx = ST_WDATA;
                        else if (quad_mode) state_nx = ST_DUMMY;
                        else               state_nx = ST_RDATA;
                    end
                end
                ST_DUMMY: if (byte_done && byte_cnt == 2'(SQI_DUMMY_BYTES-1)) state_nx = ST_RDATA;
                ST_WDATA: mem_we = byte_done & ~reset;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            quad_mode <= 1'b0;
            cmd_error <= 1'b0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            is_read   <= 1'b0;
            addr      <= '0;
            dout      <= '0;
            tx_cnt    <= '0;
        end else begin
            state <= state_nx;

            // Partial bytes vanish here: counters restart whenever deselected.
            if (state == ST_IDLE || cs_rise) bit_cnt <= '0;
            else if (rise)                   bit_cnt <= byte_done ? 3'd0 : bit_cnt + 3'd1;

            if (rise) rx_sh <= rx_byte;

            if (state == ST_IDLE)  byte_cnt <= '0;
            else if (byte_done)    byte_cnt <= (state_nx != state) ? 2'd0 : byte_cnt + 2'd1;

            if (state == ST_CMD && byte_done) begin
                is_read <= (rx_byte == CMD_READ);
                addr    <= '0;
                case (rx_byte)
                    CMD_EQIO:            quad_mode <= 1'b1;
                    CMD_RSTIO:           quad_mode <= 1'b0;
                    CMD_READ, CMD_WRITE: ;
                    default:             cmd_error <= 1'b1;
                endcase
            end

            // Only the low address bits survive the 24-bit shift.
            if (state == ST_ADDR && byte_done)
                addr <= MEM_ADDR_WIDTH'({addr, rx_byte});

            if (mem_we) addr <= addr + MEM_ADDR_WIDTH'(1);

            if (state_nx == ST_RDATA && state != ST_RDATA) begin
                dout   <= '0;
                tx_cnt <= '0;
            end else if (state == ST_RDATA && fall) begin
                if (tx_cnt == 3'd0) begin
                    // mem_q already holds the byte at addr; bumping addr now
                    // leaves a whole byte time for the next fetch.
                    dout   <= mem_q;
                    addr   <= addr + MEM_ADDR_WIDTH'(1);
                    tx_cnt <= 3'd1;
                end else begin
                    dout   <= quad_mode ? {dout[3:0], 4'h0} : {dout[6:0], 1'b0};
                    tx_cnt <= (tx_cnt == bit_last) ? 3'd0 : tx_cnt + 3'd1;
                end
            end
        end
    end

    logic [7:0] mem [0:(1<<MEM_ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= rx_byte;
`ifdef QSPI_SRAM_RESP_BACKDOOR_EN
        if (bd_we) mem[bd_addr] <= bd_wdata;
        bd_rdata <= mem[bd_addr];
`endif
        mem_q <= mem[addr];
    end

    // Output enable follows the raw pin so the bus releases without sync delay.
    assign sram_sio_oe = (state == ST_RDATA && !sram_cs_n) ? (quad_mode ? 4'b1111 : 4'b0010)
                                                           : 4'b0000;
    assign sram_sio_o  = (quad_mode ? dout[7:4] : {2'b00, dout[7], 1'b0}) & sram_sio_oe;
    assign active      = ~cs_n_sync;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed bench for qspi_sram_responder: bit-banged SPI/SQI initiator,
// byte model of the array and an expected-read-data queue.
module tb_qspi_sram_responder;

    localparam int H    = 4;           // clk cycles per sck half period
    localparam int MASK = 32'h1FFFF;

    logic       clk = 1'b0;
    logic       reset, cs_n, sck;
    logic [3:0] sio_i, sio_o, sio_oe;
    logic       quad_mode, active, cmd_error;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [int];

    always #5 clk = ~clk;

    qspi_sram_responder #(.MEM_ADDR_WIDTH(17), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .sram_cs_n   (cs_n),
        .sram_sck    (sck),
        .sram_sio_i  (sio_i),
        .sram_sio_o  (sio_o),
        .sram_sio_oe (sio_oe),
        .quad_mode   (quad_mode),
        .active      (active),
        .cmd_error   (cmd_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte, MSB first. rx/oe are what the initiator sees before each rise.
    task automatic xfer(input logic [7:0] tx, input bit quad,
                        output logic [7:0] rx, output logic [3:0] oe);
        rx = '0;
        oe = '0;
        if (quad) begin
            for (int i = 1; i >= 0; i--) begin
                sio_i = tx[i*4 +: 4];
                wait_clk(H);
                rx[i*4 +: 4] = sio_o;
                if (i == 1) oe = sio_oe;
                sck = 1'b1;
                wait_clk(H);
                sck = 1'b0;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                sio_i = {3'b000, tx[i]};
                wait_clk(H);
                rx[i] = sio_o[1];
                if (i == 7) oe = sio_oe;
                sck = 1'b1;
                wait_clk(H);
                sck = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] tx, input bit quad);
        logic [7:0] rx;
        logic [3:0] oe;
        xfer(tx, quad, rx, oe);
    endtask

    task automatic begin_txn();
        cs_n = 1'b0;
        wait_clk(H);
    endtask

    task automatic end_txn();
        wait_clk(H);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_addr(input int a, input bit quad);
        send(a[23:16], quad);
        send(a[15:8], quad);
        send(a[7:0], quad);
    endtask

    task automatic single_cmd(input logic [7:0] op, input bit quad);
        begin_txn();
        send(op, quad);
        end_txn();
    endtask

    task automatic write_n(input int a, input int n, input logic [7:0] d0,
                           input logic [7:0] d1, input bit quad);
        begin_txn();
        send(8'h02, quad);
        send_addr(a, quad);
        for (int k = 0; k < n; k++) begin
            send(k == 0 ? d0 : d1, quad);
            model[(a + k) & MASK] = (k == 0) ? d0 : d1;
        end
        end_txn();
    endtask

    task automatic read_n(input int a, input int n, input bit quad, input string tag);
        logic [7:0] rx;
        logic [3:0] oe;
        for (int k = 0; k < n; k++) exp_q.push_back(model[(a + k) & MASK]);
        begin_txn();
        send(8'h03, quad);
        send_addr(a, quad);
        if (quad) begin
            check({tag, "_oe_dummy"}, sio_oe, 4'b0000);
            send(8'h00, quad);
        end
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, quad, rx, oe);
            check($sformatf("%s_oe%0d", tag, k), oe, quad ? 4'b1111 : 4'b0010);
            check($sformatf("%s_d%0d", tag, k), rx, exp_q.pop_front());
        end
        wait_clk(H);
        cs_n = 1'b1;
        #1;
        check({tag, "_oe_release"}, sio_oe, 4'b0000);
        wait_clk(6);
    endtask

    initial begin
        logic [7:0] rx;
        logic [3:0] oe;
        reset = 1'b1;
        cs_n  = 1'b1;
        sck   = 1'b0;
        sio_i = 4'h0;
        wait_clk(5);
        check("rst_quad", quad_mode, 1'b0);
        check("rst_oe", sio_oe, 4'b0000);
        check("rst_sio_o", sio_o, 4'b0000);
        check("rst_active", active, 1'b0);
        check("rst_cmd_error", cmd_error, 1'b0);
        reset = 1'b0;
        wait_clk(4);

        // SPI write/read
        begin_txn();
        check("spi_active", active, 1'b1);
        send(8'h02, 1'b0);
        send_addr(32'h000010, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        model[32'h10] = 8'hA5;
        model[32'h11] = 8'h5A;
        end_txn();
        read_n(32'h000010, 2, 1'b0, "spi_rd");
        check("spi_quad", quad_mode, 1'b0);

        // SQI
        single_cmd(8'h38, 1'b0);
        check("eqio_quad", quad_mode, 1'b1);
        write_n(32'h000100, 2, 8'h12, 8'h34, 1'b1);
        read_n(32'h000100, 2, 1'b1, "sqi_rd");

        // Address wrap on write and read
        write_n(32'h01FFFF, 2, 8'h11, 8'h22, 1'b1);
        read_n(32'h01FFFF, 2, 1'b1, "wrap_rd");
        read_n(32'h000000, 1, 1'b1, "wrap_rd0");

        // Aborted write leaves the byte untouched
        write_n(32'h000020, 1, 8'h3C, 8'h00, 1'b1);
        begin_txn();
        send(8'h02, 1'b1);
        send_addr(32'h000020, 1'b1);
        sio_i = 4'hF;
        wait_clk(H);
        sck = 1'b1;
        wait_clk(H);
        sck = 1'b0;
        end_txn();
        read_n(32'h000020, 1, 1'b1, "abort_rd");

        // RSTIO in SQI, then bad opcode in SPI
        single_cmd(8'hFF, 1'b1);
        check("rstio_quad", quad_mode, 1'b0);
        check("pre_cmd_error", cmd_error, 1'b0);
        begin_txn();
        send(8'h05, 1'b0);
        xfer(8'h00, 1'b0, rx, oe);
        check("badop_oe", oe, 4'b0000);
        end_txn();
        check("badop_cmd_error", cmd_error, 1'b1);

        // Reset in the middle of an SQI read
        single_cmd(8'h38, 1'b0);
        begin_txn();
        send(8'h03, 1'b1);
        send_addr(32'h000100, 1'b1);
        send(8'h00, 1'b1);
        xfer(8'h00, 1'b1, rx, oe);
        check("midrd_d0", rx, 8'h12);
        sio_i = 4'h0;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(2);
        check("midrst_oe", sio_oe, 4'b0000);
        check("midrst_quad", quad_mode, 1'b0);
        check("midrst_active", active, 1'b0);
        check("midrst_cmd_error", cmd_error, 1'b0);
        cs_n = 1'b1;
        sck  = 1'b0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(4);
        read_n(32'h000100, 2, 1'b0, "postrst_rd");
        read_n(32'h000010, 1, 1'b0, "postrst_rd10");

        // Encoder-style bring-up: RSTIO, EQIO, word at hack address 0x3FFF
        single_cmd(8'hFF, 1'b0);
        single_cmd(8'h38, 1'b0);
        check("soc_quad", quad_mode, 1'b1);
        write_n(32'h3FFF << 1, 2, 8'hBE, 8'hEF, 1'b1);
        read_n(32'h3FFF << 1, 2, 1'b1, "soc_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
